// File: rtl/tone_pkg.sv
// Shared types for the tone sequencer: FSM state encoding and default C4..B5
// half-periods at 50 MHz for board software that preloads the tone table.
package tone_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2
   } state_e;

   localparam int unsigned HP_C4 = 95556;
   localparam int unsigned HP_D4 = 85131;
   localparam int unsigned HP_E4 = 75843;
   localparam int unsigned HP_F4 = 71586;
   localparam int unsigned HP_G4 = 63776;
   localparam int unsigned HP_A4 = 56818;
   localparam int unsigned HP_B4 = 50619;
   localparam int unsigned HP_C5 = 47778;
   localparam int unsigned HP_D5 = 42566;
   localparam int unsigned HP_E5 = 37922;
   localparam int unsigned HP_F5 = 35793;
   localparam int unsigned HP_G5 = 31888;
   localparam int unsigned HP_A5 = 28409;
   localparam int unsigned HP_B5 = 25310;

   // Note codes 1..14 map to C4..B5 in order; code 0 is a rest.
   localparam int unsigned DEFAULT_HP [14] = '{
      HP_C4, HP_D4, HP_E4, HP_F4, HP_G4, HP_A4, HP_B4,
      HP_C5, HP_D5, HP_E5, HP_F5, HP_G5, HP_A5, HP_B5
   };

   // Halving a half-period raises the pitch by one octave, keeping the note name.
   function automatic int unsigned fit_hp(int unsigned hp, int unsigned tone_w);
      int unsigned v;
      v = hp;
      if (tone_w < 32) begin
         for (int unsigned i = 0; i < 32; i++) begin
            if (v >= (32'd1 << tone_w)) v = v >> 1;
         end
      end
      return v;
   endfunction

   function automatic int unsigned default_hp(int unsigned code, int unsigned tone_w);
      if (code == 0 || code > 14) return 0;
      return fit_hp(DEFAULT_HP[code - 1], tone_w);
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: output toggles every hp_i enabled cycles; restart_i
// re-phases the wave, freeze_i holds the phase while silencing the output.
module tone_gen #(
   parameter int unsigned TONE_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [TONE_W-1:0] hp_i,
   input  logic              enable_i,
   input  logic              restart_i,
   input  logic              freeze_i,
   output logic              spk_o
);

   logic [TONE_W-1:0] cnt_q, cnt_d;
   logic              phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (restart_i || (!enable_i && !freeze_i)) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (enable_i) begin
         // >= rather than == so a shrinking table entry cannot strand the counter.
         if (cnt_q >= hp_i - TONE_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + TONE_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign spk_o = phase_q & enable_i;

endmodule

// File: rtl/tone_sequencer.sv
// Loadable song player: song memory, tone table, beat FSM and speaker drive.
// Optional macro NOTE_GAP_EN silences the first GAP_CYC cycles of every note.
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int unsigned BEAT_DIV = 12500000,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned NOTE_W   = 4,
   parameter int unsigned TONE_W   = 16,
   parameter int unsigned GAP_CYC  = 1250000
) (
   input  logic              CLK0,
   input  logic              RST0,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [NOTE_W-1:0] wr_data,
   input  logic              tbl_we,
   input  logic [NOTE_W-1:0] tbl_addr,
   input  logic [TONE_W-1:0] tbl_data,
   input  logic [AW-1:0]     len,
   input  logic              start,
   input  logic              pause,
   input  logic              loop,
   output logic              SPK_KX,
   output logic [NOTE_W-1:0] LED,
   output logic [AW-1:0]     idx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned BW = $clog2(BEAT_DIV);

`ifdef NOTE_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [AW-1:0]     idx_q, idx_d, idx_nxt;
   logic [NOTE_W-1:0] note_q, note_d;
   logic              done_q, done_d;
   logic              note_start;

   logic [NOTE_W-1:0] song_q [DEPTH];
   logic [TONE_W-1:0] tbl_q  [2**NOTE_W];

   logic [TONE_W-1:0] hp;
   logic              gap;
   logic              tone_en;
   logic              spk;

   always_ff @(posedge CLK0 or negedge RST0) begin
      if (!RST0) begin
         for (int unsigned i = 0; i < DEPTH; i++) song_q[i] <= '0;
      end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
         song_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge CLK0 or negedge RST0) begin
      if (!RST0) begin
         for (int unsigned i = 0; i < 2**NOTE_W; i++) tbl_q[i] <= '0;
      end else if (tbl_we) begin
         tbl_q[tbl_addr] <= tbl_data;
      end
   end

   // An over-long len never matches idx, so the index just wraps at DEPTH-1.
   assign idx_nxt = (idx_q == AW'(DEPTH - 1)) ? '0 : idx_q + AW'(1);

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      idx_d      = idx_q;
      note_d     = note_q;
      done_d     = 1'b0;
      note_start = 1'b0;
      if (start) begin
         state_d    = PLAY;
         beat_d     = '0;
         idx_d      = '0;
         note_d     = song_q[0];
         note_start = 1'b1;
      end else begin
         case (state_q)
            PLAY: begin
               if (pause) begin
                  state_d = PAUSE;
               end else if (beat_q == BW'(BEAT_DIV - 1)) begin
                  beat_d = '0;
                  if (idx_q != len) begin
                     idx_d      = idx_nxt;
                     note_d     = song_q[idx_nxt];
                     note_start = 1'b1;
                  end else if (loop) begin
                     idx_d      = '0;
                     note_d     = song_q[0];
                     note_start = 1'b1;
                  end else begin
                     state_d = IDLE;
                     idx_d   = '0;
                     note_d  = '0;
                     done_d  = 1'b1;
                  end
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
            PAUSE: begin
               if (!pause) state_d = PLAY;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK0 or negedge RST0) begin
      if (!RST0) begin
         state_q <= IDLE;
         beat_q  <= '0;
         idx_q   <= '0;
         note_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         idx_q   <= idx_d;
         note_q  <= note_d;
         done_q  <= done_d;
      end
   end

   assign hp      = tbl_q[note_q];
   assign gap     = GAP_ON && (beat_q < BW'(GAP_CYC));
   assign tone_en = (state_q == PLAY) && (note_q != '0) && (hp != '0) && !gap;

   tone_gen #(
      .TONE_W(TONE_W)
   ) u_tone_gen (
      .clk_i     (CLK0),
      .rst_ni    (RST0),
      .hp_i      (hp),
      .enable_i  (tone_en),
      .restart_i (note_start),
      .freeze_i  (state_q == PAUSE),
      .spk_o     (spk)
   );

   assign SPK_KX = spk;
   assign busy   = (state_q != IDLE);
   assign LED    = busy ? note_q : '0;
   assign idx    = idx_q;
   assign done   = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: song vector table with a scoreboard of per-cycle
// expectations, plus hand-written loop, pause, restart, reset and rewrite sequences.
module tb_tone_sequencer;

   localparam int unsigned BD  = 20;
   localparam int unsigned DP  = 8;
   localparam int unsigned AWP = 3;
   localparam int unsigned NW  = 4;
   localparam int unsigned TW  = 8;
   localparam int unsigned GC  = 4;
`ifdef NOTE_GAP_EN
   localparam int unsigned GAP = GC;
`else
   localparam int unsigned GAP = 0;
`endif

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b0;
   logic           wr_en    = 1'b0;
   logic [AWP-1:0] wr_addr  = '0;
   logic [NW-1:0]  wr_data  = '0;
   logic           tbl_we   = 1'b0;
   logic [NW-1:0]  tbl_addr = '0;
   logic [TW-1:0]  tbl_data = '0;
   logic [AWP-1:0] len      = '0;
   logic           start    = 1'b0;
   logic           pause    = 1'b0;
   logic           loop     = 1'b0;
   logic           spk;
   logic [NW-1:0]  led;
   logic [AWP-1:0] idx;
   logic           busy;
   logic           done;

   always #5 clk = ~clk;

   tone_sequencer #(
      .BEAT_DIV (BD),
      .DEPTH    (DP),
      .AW       (AWP),
      .NOTE_W   (NW),
      .TONE_W   (TW),
      .GAP_CYC  (GC)
   ) dut (
      .CLK0     (clk),
      .RST0     (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .tbl_we   (tbl_we),
      .tbl_addr (tbl_addr),
      .tbl_data (tbl_data),
      .len      (len),
      .start    (start),
      .pause    (pause),
      .loop     (loop),
      .SPK_KX   (spk),
      .LED      (led),
      .idx      (idx),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      string      name;
      logic [9:0] exp;
   } sb_t;

   typedef struct {
      string          name;
      logic [NW-1:0]  s0, s1, s2, s3;
      logic [AWP-1:0] last;
   } vec_t;

   sb_t           sb_q [$];
   vec_t          vecs [4];
   logic [NW-1:0] song_m [DP];
   logic [TW-1:0] tbl_m [16];
   int            checks   = 0;
   int            failures = 0;

   function automatic vec_t mk(string nm, int unsigned a, int unsigned b, int unsigned c,
                               int unsigned d, int unsigned l);
      vec_t r;
      r.name = nm;
      r.s0 = NW'(a);
      r.s1 = NW'(b);
      r.s2 = NW'(c);
      r.s3 = NW'(d);
      r.last = AWP'(l);
      return r;
   endfunction

   // Observed vector: {busy, done, idx, LED, SPK_KX}
   function automatic logic [9:0] obs();
      return {busy, done, idx, led, spk};
   endfunction

   // Closed-form square wave: high during odd half-periods after the optional gap.
   function automatic logic spk_exp(logic [NW-1:0] code, int unsigned p);
      int unsigned hp;
      hp = 32'(tbl_m[code]);
      if (code == '0 || hp == 0 || p < GAP) return 1'b0;
      return (((p - GAP) / hp) % 2) == 1;
   endfunction

   function automatic logic [9:0] play_exp(int unsigned t, int unsigned n, logic [NW-1:0] code);
      return {1'b1, 1'b0, AWP'(n), code, spk_exp(code, t % BD)};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(string name, logic [9:0] e);
      sb_t r;
      r.name = name;
      r.exp  = e;
      sb_q.push_back(r);
   endtask

   task automatic pop_check();
      sb_t r;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
         r = sb_q.pop_front();
         check(r.name, 32'(obs()), 32'(r.exp));
      end
   endtask

   task automatic run_sb(int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         @(negedge clk);
         pop_check();
         tick();
      end
   endtask

   task automatic wr_song(int unsigned a, int unsigned d);
      wr_en   = 1'b1;
      wr_addr = AWP'(a);
      wr_data = NW'(d);
      song_m[AWP'(a)] = NW'(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wr_tbl(int unsigned a, int unsigned d);
      tbl_we   = 1'b1;
      tbl_addr = NW'(a);
      tbl_data = TW'(d);
      tbl_m[NW'(a)] = TW'(d);
      tick();
      tbl_we = 1'b0;
   endtask

   task automatic start_play();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int unsigned k;
      k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      check(name, 32'(busy), 32'(0));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned n;
      logic [NW-1:0] lat;
      logic done_seen;

      for (int unsigned i = 0; i < DP; i++) song_m[i] = '0;
      for (int unsigned i = 0; i < 16; i++) tbl_m[i] = '0;
      vecs[0] = mk("song_a", 1, 2, 0, 1, 3);
      vecs[1] = mk("song_b", 2, 3, 1, 0, 2);
      vecs[2] = mk("song_c", 3, 0, 0, 0, 0);
      vecs[3] = mk("song_d", 5, 1, 0, 0, 1);

      #3;
      check("reset_outputs", 32'(obs()), 32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      wr_tbl(1, 3);
      wr_tbl(2, 5);
      wr_tbl(3, 0);

      // One-shot songs: every cycle of playback plus the done pulse and the cycle after.
      for (int unsigned v = 0; v < 4; v++) begin
         wr_song(0, 32'(vecs[v].s0));
         wr_song(1, 32'(vecs[v].s1));
         wr_song(2, 32'(vecs[v].s2));
         wr_song(3, 32'(vecs[v].s3));
         len  = vecs[v].last;
         loop = 1'b0;
         n = (32'(vecs[v].last) + 1) * BD;
         for (int unsigned t = 0; t < n + 2; t++) begin
            if (t < n)
               push($sformatf("%s_t%0d", vecs[v].name, t),
                    play_exp(t, t / BD, song_m[AWP'(t / BD)]));
            else if (t == n)
               push($sformatf("%s_done", vecs[v].name), {1'b0, 1'b1, 3'd0, 4'd0, 1'b0});
            else
               push($sformatf("%s_after", vecs[v].name), 10'd0);
         end
         start_play();
         run_sb(n + 2);
      end

      // Loop mode: idx wraps, no done; dropping loop during idx 3 stops at note end.
      wr_song(0, 1);
      wr_song(1, 2);
      wr_song(2, 0);
      wr_song(3, 1);
      len  = 3'd3;
      loop = 1'b1;
      done_seen = 1'b0;
      start_play();
      for (int unsigned t = 0; t < 160; t++) begin
         @(negedge clk);
         if (t % BD == 0) check($sformatf("loop_idx_t%0d", t), 32'(idx), (t / BD) % 4);
         if (t == 159) check("loop_last_note", 32'({busy, idx}), 32'({1'b1, 3'd3}));
         done_seen = done_seen | done;
         if (t == 145) loop = 1'b0;
         tick();
      end
      check("loop_no_done", 32'(done_seen), 32'(0));
      @(negedge clk);
      check("loop_stop_done", 32'({busy, done}), 32'(2'b01));
      tick();
      @(negedge clk);
      check("loop_done_one_cycle", 32'(done), 32'(0));
      tick();

      // Rewriting the playing address affects only the next visit of that index.
      wr_song(0, 1);
      wr_song(1, 1);
      len  = 3'd1;
      loop = 1'b1;
      lat  = '0;
      start_play();
      for (int unsigned t = 0; t < 4 * BD; t++) begin
         if (t % BD == 0) lat = song_m[AWP'((t / BD) % 2)];
         push($sformatf("wrplay_t%0d", t), play_exp(t, (t / BD) % 2, lat));
         @(negedge clk);
         pop_check();
         if (t == 25) begin
            wr_en   = 1'b1;
            wr_addr = 3'd1;
            wr_data = 4'd2;
            song_m[1] = 4'd2;
         end else begin
            wr_en = 1'b0;
         end
         if (t == 4 * BD - 1) loop = 1'b0;
         tick();
      end
      wr_en = 1'b0;
      wait_idle("wrplay_stop");

      // Pause for 30 cycles starting 7 cycles into note 1.
      wr_song(1, 2);
      len  = 3'd3;
      loop = 1'b0;
      start_play();
      for (int unsigned t = 0; t < 72; t++) begin
         @(negedge clk);
         if (t >= 28 && t <= 57)
            check($sformatf("pause_hold_t%0d", t), 32'({busy, idx, spk}), 32'({1'b1, 3'd1, 1'b0}));
         if (t == 70) check("pause_resume_last", 32'(idx), 32'(1));
         if (t == 71) check("pause_resume_next", 32'(idx), 32'(2));
         pause = (t >= 27 && t <= 56);
         tick();
      end
      pause = 1'b0;
      wait_idle("pause_stop");

      // start and pause together at idx 2 restart playback; then an async reset mid-note.
      start_play();
      for (int unsigned t = 0; t < 55; t++) begin
         @(negedge clk);
         if (t == 46) check("sp_restart", 32'({busy, idx, led}), 32'({1'b1, 3'd0, 4'd1}));
         if (t == 49) check("sp_play_tone", 32'(spk), 32'(spk_exp(song_m[0], 3)));
         start = (t == 45);
         pause = (t == 45);
         tick();
      end
      start = 1'b0;
      pause = 1'b0;
      #1;
      check("pre_reset_state", 32'({busy, led, spk}), 32'({1'b1, 4'd1, spk_exp(song_m[0], 9)}));
      rst_n = 1'b0;
      #1;
      check("reset_async", 32'(obs()), 32'(0));
      for (int unsigned i = 0; i < DP; i++) song_m[i] = '0;
      for (int unsigned i = 0; i < 16; i++) tbl_m[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Both memories must come out of reset cleared.
      wr_song(0, 1);
      len  = 3'd1;
      loop = 1'b0;
      for (int unsigned t = 0; t < 2 * BD; t++)
         push($sformatf("postrst_t%0d", t), play_exp(t, t / BD, song_m[AWP'(t / BD)]));
      push("postrst_done", {1'b0, 1'b1, 3'd0, 4'd0, 1'b0});
      start_play();
      run_sb(2 * BD + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
